// File: rtl/alu_seq_pkg.sv
// Shared state encodings and ALU opcode constants for the
// operand sequencer and its bench.
package alu_seq_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        S_LOAD_A  = 3'd0,
        S_LOAD_B  = 3'd1,
        S_LOAD_OP = 3'd2,
        S_EXEC    = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    localparam logic [5:0] OP_ADD = 6'b100000;
    localparam logic [5:0] OP_SUB = 6'b100010;
    localparam logic [5:0] OP_AND = 6'b100100;
    localparam logic [5:0] OP_OR  = 6'b100101;
    localparam logic [5:0] OP_XOR = 6'b100110;
    localparam logic [5:0] OP_NOR = 6'b100111;
    localparam logic [5:0] OP_SRA = 6'b000011;
    localparam logic [5:0] OP_SRL = 6'b000010;

endpackage

// File: rtl/alu_operand_sequencer_btn_conditioner.sv
// Button path: 2-FF synchroniser, optional debouncer, rising-edge pulse.
// Debouncer is built only when ALU_SEQ_DEBOUNCE_EN is defined.
module btn_conditioner #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_btn,
    output logic o_pulse
);

    logic sync_q1;
    logic sync_q2;
    logic level;
    logic level_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
        end else begin
            sync_q1 <= i_btn;
            sync_q2 <= sync_q1;
        end
    end

`ifdef ALU_SEQ_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic [CNT_W-1:0] cnt;
    logic             filt;

    // Filtered level flips only after DEBOUNCE_CYCLES agreeing samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            filt <= 1'b0;
        end else if (sync_q2 == filt) begin
            cnt <= '0;
        end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            cnt  <= '0;
            filt <= sync_q2;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign level = filt;
`else
    localparam int unused_dbc = DEBOUNCE_CYCLES;

    assign level = sync_q2;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_q <= 1'b0;
        end else begin
            level_q <= level;
        end
    end

    assign o_pulse = level & ~level_q;

endmodule

// File: rtl/alu_operand_sequencer.sv
// Loads A, B and opcode from one switch bank, runs one ALU
// evaluation and holds the result. Option: ALU_SEQ_DEBOUNCE_EN.
module alu_operand_sequencer
    import alu_seq_pkg::*;
#(
    parameter int DATA_W          = 8,
    parameter int OP_W            = 6,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] i_sw,
    input  logic              i_btn_load,
    input  logic              i_btn_clear,
    output logic [DATA_W-1:0] o_alu_a,
    output logic [DATA_W-1:0] o_alu_b,
    output logic [OP_W-1:0]   o_alu_op,
    input  logic [DATA_W-1:0] i_alu_result,
    output logic [DATA_W-1:0] o_result,
    output logic              o_result_valid,
    output logic [2:0]        o_state
);

    logic ld_pulse;
    logic clr_pulse;

    btn_conditioner #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_load (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_btn  (i_btn_load),
        .o_pulse(ld_pulse)
    );

    btn_conditioner #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_clear (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_btn  (i_btn_clear),
        .o_pulse(clr_pulse)
    );

    state_t            state_q;
    state_t            state_n;
    logic [DATA_W-1:0] a_n;
    logic [DATA_W-1:0] b_n;
    logic [OP_W-1:0]   op_n;
    logic [DATA_W-1:0] res_n;
    logic              valid_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_LOAD_A;
            o_alu_a        <= '0;
            o_alu_b        <= '0;
            o_alu_op       <= '0;
            o_result       <= '0;
            o_result_valid <= 1'b0;
        end else begin
            state_q        <= state_n;
            o_alu_a        <= a_n;
            o_alu_b        <= b_n;
            o_alu_op       <= op_n;
            o_result       <= res_n;
            o_result_valid <= valid_n;
        end
    end

    // Clear outranks everything, so a coincident load is dropped.
    always_comb begin
        state_n = state_q;
        a_n     = o_alu_a;
        b_n     = o_alu_b;
        op_n    = o_alu_op;
        res_n   = o_result;
        valid_n = o_result_valid;
        if (clr_pulse) begin
            state_n = S_LOAD_A;
            a_n     = '0;
            b_n     = '0;
            op_n    = '0;
            res_n   = '0;
            valid_n = 1'b0;
        end else begin
            case (state_q)
                S_LOAD_A: begin
                    if (ld_pulse) begin
                        a_n     = i_sw;
                        state_n = S_LOAD_B;
                    end
                end
                S_LOAD_B: begin
                    if (ld_pulse) begin
                        b_n     = i_sw;
                        state_n = S_LOAD_OP;
                    end
                end
                S_LOAD_OP: begin
                    if (ld_pulse) begin
                        op_n    = i_sw[OP_W-1:0];
                        state_n = S_EXEC;
                    end
                end
                S_EXEC: begin
                    res_n   = i_alu_result;
                    valid_n = 1'b1;
                    state_n = S_DONE;
                end
                S_DONE: begin
                    if (ld_pulse) begin
                        valid_n = 1'b0;
                        a_n     = i_sw;
                        state_n = S_LOAD_B;
                    end
                end
                default: state_n = S_LOAD_A;
            endcase
        end
    end

    assign o_state = state_q;

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Directed bench for alu_operand_sequencer with a reference ALU.
// Glitch expectations follow ALU_SEQ_DEBOUNCE_EN.
module tb_alu_operand_sequencer;
    import alu_seq_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] i_sw;
    logic       i_btn_load;
    logic       i_btn_clear;
    logic [7:0] o_alu_a;
    logic [7:0] o_alu_b;
    logic [5:0] o_alu_op;
    logic [7:0] i_alu_result;
    logic [7:0] o_result;
    logic       o_result_valid;
    logic [2:0] o_state;

    int n_checks = 0;
    int n_fail   = 0;

    alu_operand_sequencer dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_sw          (i_sw),
        .i_btn_load    (i_btn_load),
        .i_btn_clear   (i_btn_clear),
        .o_alu_a       (o_alu_a),
        .o_alu_b       (o_alu_b),
        .o_alu_op      (o_alu_op),
        .i_alu_result  (i_alu_result),
        .o_result      (o_result),
        .o_result_valid(o_result_valid),
        .o_state       (o_state)
    );

    always #5 clk = ~clk;

    always_comb begin
        case (o_alu_op)
            OP_ADD:  i_alu_result = o_alu_a + o_alu_b;
            OP_SUB:  i_alu_result = o_alu_a - o_alu_b;
            OP_AND:  i_alu_result = o_alu_a & o_alu_b;
            OP_OR:   i_alu_result = o_alu_a | o_alu_b;
            OP_XOR:  i_alu_result = o_alu_a ^ o_alu_b;
            OP_NOR:  i_alu_result = ~(o_alu_a | o_alu_b);
            OP_SRA:  i_alu_result = $signed(o_alu_a) >>> o_alu_b[2:0];
            OP_SRL:  i_alu_result = o_alu_a >> o_alu_b[2:0];
            default: i_alu_result = 8'h00;
        endcase
    end

    // {state, a, b, op, valid, result}
    wire [33:0] snap = {o_state, o_alu_a, o_alu_b, o_alu_op,
                        o_result_valid, o_result};

    task automatic press_load(input logic [7:0] sw, input int hold);
        i_sw = sw;
        @(negedge clk);
        i_btn_load = 1'b1;
        repeat (hold) @(negedge clk);
        i_btn_load = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    task automatic press_clear();
        @(negedge clk);
        i_btn_clear = 1'b1;
        repeat (6) @(negedge clk);
        i_btn_clear = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (snap !== 34'h0) begin
            n_fail++;
            $display("FAIL por_low: got %h exp %h", snap, 34'h0);
        end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if (snap !== 34'h0) begin
            n_fail++;
            $display("FAIL por_release: got %h exp %h", snap, 34'h0);
        end
    endtask

    task automatic test_reset_mid_op();
        press_load(8'h12, 6);
        press_load(8'h34, 6);
        n_checks++;
        if (snap !== {3'd2, 8'h12, 8'h34, 6'h00, 1'b0, 8'h00}) begin
            n_fail++;
            $display("FAIL pre_reset: got %h", snap);
        end
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        n_checks++;
        if (snap !== 34'h0) begin
            n_fail++;
            $display("FAIL rst_mid_low: got %h exp %h", snap, 34'h0);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if (snap !== 34'h0) begin
            n_fail++;
            $display("FAIL rst_mid_after: got %h exp %h", snap, 34'h0);
        end
    endtask

    task automatic test_ops();
        press_load(8'h0F, 6);
        press_load(8'hF0, 6);
        press_load({2'b00, OP_NOR}, 6);
        n_checks++;
        if (snap !== {3'd4, 8'h0F, 8'hF0, 6'h27, 1'b1, 8'h00}) begin
            n_fail++;
            $display("FAIL nor_op: got %h", snap);
        end
        press_load(8'hFF, 6);
        n_checks++;
        if (snap !== {3'd1, 8'hFF, 8'hF0, 6'h27, 1'b0, 8'h00}) begin
            n_fail++;
            $display("FAIL chain_a: got %h", snap);
        end
        press_load(8'h01, 6);
        press_load({2'b00, OP_ADD}, 6);
        n_checks++;
        if (snap !== {3'd4, 8'hFF, 8'h01, 6'h20, 1'b1, 8'h00}) begin
            n_fail++;
            $display("FAIL add_wrap: got %h", snap);
        end
        press_load(8'h5A, 6);
        press_load(8'hFF, 6);
        press_load({2'b00, OP_XOR}, 6);
        n_checks++;
        if (snap !== {3'd4, 8'h5A, 8'hFF, 6'h26, 1'b1, 8'hA5}) begin
            n_fail++;
            $display("FAIL xor_op: got %h", snap);
        end
    endtask

    task automatic test_held_button();
        press_clear();
        n_checks++;
        if (snap !== 34'h0) begin
            n_fail++;
            $display("FAIL clear_done: got %h exp %h", snap, 34'h0);
        end
        press_load(8'hA7, 20);
        n_checks++;
        if (snap !== {3'd1, 8'hA7, 8'h00, 6'h00, 1'b0, 8'h00}) begin
            n_fail++;
            $display("FAIL held_load: got %h", snap);
        end
    endtask

    task automatic test_clear_load_collision();
        press_clear();
        press_load(8'h11, 6);
        press_load(8'h22, 6);
        i_sw = 8'h3C;
        @(negedge clk);
        i_btn_load  = 1'b1;
        i_btn_clear = 1'b1;
        repeat (6) @(negedge clk);
        i_btn_load  = 1'b0;
        i_btn_clear = 1'b0;
        repeat (10) @(negedge clk);
        n_checks++;
        if (snap !== 34'h0) begin
            n_fail++;
            $display("FAIL clr_vs_load: got %h exp %h", snap, 34'h0);
        end
    endtask

    task automatic test_chain();
        press_load(8'h3C, 6);
        press_load(8'h0F, 6);
        press_load({2'b00, OP_AND}, 6);
        n_checks++;
        if (snap !== {3'd4, 8'h3C, 8'h0F, 6'h24, 1'b1, 8'h0C}) begin
            n_fail++;
            $display("FAIL and_op: got %h", snap);
        end
        press_load(8'h55, 6);
        n_checks++;
        if (snap !== {3'd1, 8'h55, 8'h0F, 6'h24, 1'b0, 8'h0C}) begin
            n_fail++;
            $display("FAIL chain_hold: got %h", snap);
        end
    endtask

    task automatic test_glitch();
        logic [33:0] exp_glitch;
        logic [33:0] exp_press;
`ifdef ALU_SEQ_DEBOUNCE_EN
        exp_glitch = 34'h0;
        exp_press  = {3'd1, 8'h66, 8'h00, 6'h00, 1'b0, 8'h00};
`else
        exp_glitch = {3'd1, 8'h99, 8'h00, 6'h00, 1'b0, 8'h00};
        exp_press  = {3'd2, 8'h99, 8'h66, 6'h00, 1'b0, 8'h00};
`endif
        press_clear();
        press_load(8'h99, 3);
        n_checks++;
        if (snap !== exp_glitch) begin
            n_fail++;
            $display("FAIL glitch: got %h exp %h", snap, exp_glitch);
        end
        press_load(8'h66, 6);
        n_checks++;
        if (snap !== exp_press) begin
            n_fail++;
            $display("FAIL press6: got %h exp %h", snap, exp_press);
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        i_sw        = 8'h00;
        i_btn_load  = 1'b0;
        i_btn_clear = 1'b0;
        test_reset();
        test_reset_mid_op();
        test_ops();
        test_held_button();
        test_clear_load_collision();
        test_chain();
        test_glitch();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
